// File: rtl/seq_scheduler_if.sv
// Host command byte stream into seq_scheduler.
//   cmd_valid : host has a table byte on cmd_data
//   cmd_ready : scheduler accepts the byte on this clock edge
//   cmd_data  : table byte, high byte of each 16-bit word first
// master = host side, slave = scheduler side.
interface seq_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/seq_scheduler.sv
// Sequencer scheduler: downloads a 16-bit word table into the sequencer one byte per
// wr/stb strobe, then launches timed sequencer runs (seq_en pulses) with inter-run gaps.
//   clk, rst_n              : clock, asynchronous active-low reset
//   cmd                     : host byte stream (valid/ready/data)
//   load_req                : pulse, start a table download
//   start, stop             : pulse, start runs / graceful stop after current run
//   run_mode .. mux_limit   : run parameters captured when start is accepted
//   flag_adc                : ADC-window flag from the sequencer
//   seq_en, wr, stb, dato   : sequencer restart, write enable, write strobe, data byte
//   mode, mux_cont_en       : table select and mux limit held for the whole run set
//   busy, load_done         : status levels
//   run_done, err_timeout   : one-cycle pulses at the end of each run
//   runs_done               : completed runs since the last accepted start (wraps)
// SEQ_LEN must be at least 3 and STB_W at least 1.
module seq_scheduler #(
    parameter int unsigned WORDS   = 64,
    parameter int unsigned SEQ_LEN = 64,
    parameter int unsigned STB_W   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_scheduler_if.slave cmd,
    input  logic           load_req,
    input  logic           start,
    input  logic           stop,
    input  logic [1:0]     run_mode,
    input  logic [7:0]     run_count,
    input  logic [7:0]     gap_cycles,
    input  logic [7:0]     mux_limit,
    input  logic           flag_adc,
    output logic           seq_en,
    output logic           wr,
    output logic           stb,
    output logic [7:0]     dato,
    output logic [1:0]     mode,
    output logic [7:0]     mux_cont_en,
    output logic           busy,
    output logic           load_done,
    output logic           run_done,
    output logic           err_timeout,
    output logic [7:0]     runs_done
);

    localparam int unsigned TmrW   = 16;
    localparam int unsigned NBytes = 2 * WORDS;
    localparam int unsigned BcW    = $clog2(NBytes + 1);

    typedef enum logic [2:0] {
        StIdle, StLdWait, StLdHi, StLdLo, StLdFlush, StArm, StRun, StGap
    } state_e;

    state_e           state_q, state_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic [BcW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]       dato_q, dato_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       mux_q, mux_d;
    logic [7:0]       count_q, count_d;
    logic [7:0]       remain_q, remain_d;
    logic [7:0]       gap_q, gap_d;
    logic [7:0]       runs_done_q, runs_done_d;
    logic             load_done_q, load_done_d;
    logic             run_done_q, run_done_d;
    logic             err_timeout_q, err_timeout_d;
    logic             stop_q, stop_d;
    logic             flag_seen_q, flag_seen_d;

    logic ld_wait;
    logic xfer;
    logic start_ok;
    logic in_run_set;

    assign ld_wait    = (state_q == StLdWait);
    assign xfer       = ld_wait && cmd.cmd_valid;
    // Table-select 3 needs a downloaded table.
    assign start_ok   = start && !((run_mode == 2'b11) && !load_done_q);
    assign in_run_set = (state_q == StArm) || (state_q == StRun) || (state_q == StGap);

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        byte_cnt_d    = byte_cnt_q;
        dato_d        = dato_q;
        mode_d        = mode_q;
        mux_d         = mux_q;
        count_d       = count_q;
        remain_d      = remain_q;
        gap_d         = gap_q;
        runs_done_d   = runs_done_q;
        load_done_d   = load_done_q;
        run_done_d    = 1'b0;
        err_timeout_d = 1'b0;
        stop_d        = stop_q || (stop && in_run_set);
        flag_seen_d   = flag_seen_q;

        unique case (state_q)
            StIdle: begin
                if (load_req) begin
                    state_d     = StLdWait;
                    load_done_d = 1'b0;
                    byte_cnt_d  = '0;
                    tmr_d       = '0;
                end else if (start_ok) begin
                    state_d     = StArm;
                    mode_d      = run_mode;
                    mux_d       = mux_limit;
                    count_d     = run_count;
                    remain_d    = run_count;
                    gap_d       = gap_cycles;
                    runs_done_d = 8'd0;
                    stop_d      = 1'b0;
                end
            end
            StLdWait: begin
                if (xfer) begin
                    state_d    = StLdHi;
                    dato_d     = cmd.cmd_data;
                    byte_cnt_d = byte_cnt_q + BcW'(1);
                    tmr_d      = '0;
                end
            end
            StLdHi: begin
                if (tmr_q == TmrW'(STB_W - 1)) begin
                    state_d = StLdLo;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StLdLo: begin
                if (tmr_q == TmrW'(STB_W - 1)) begin
                    tmr_d = '0;
                    if (byte_cnt_q == BcW'(NBytes)) begin
                        // Extra zero strobe pushes the last word into the sequencer.
                        state_d = StLdFlush;
                        dato_d  = 8'd0;
                    end else begin
                        state_d = StLdWait;
                    end
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StLdFlush: begin
                if (tmr_q == TmrW'(2 * STB_W - 1)) begin
                    state_d     = StIdle;
                    load_done_d = 1'b1;
                    tmr_d       = '0;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StArm: begin
                // tmr counts cycles since the seq_en pulse.
                state_d     = StRun;
                tmr_d       = TmrW'(1);
                flag_seen_d = 1'b0;
            end
            StRun: begin
                flag_seen_d = flag_seen_q || flag_adc;
                if (tmr_q == TmrW'(SEQ_LEN - 2)) begin
                    state_d       = StGap;
                    tmr_d         = '0;
                    run_done_d    = 1'b1;
                    err_timeout_d = !(flag_seen_q || flag_adc);
                    runs_done_d   = runs_done_q + 8'd1;
                    if (count_q != 8'd0) begin
                        remain_d = remain_q - 8'd1;
                    end
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StGap: begin
                if (tmr_q == {8'd0, gap_q}) begin
                    tmr_d = '0;
                    if (stop_q || ((count_q != 8'd0) && (remain_q == 8'd0))) begin
                        state_d = StIdle;
                        mode_d  = 2'b00;
                        mux_d   = 8'd0;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = StArm;
                    end
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            tmr_q         <= '0;
            byte_cnt_q    <= '0;
            dato_q        <= 8'd0;
            mode_q        <= 2'b00;
            mux_q         <= 8'd0;
            count_q       <= 8'd0;
            remain_q      <= 8'd0;
            gap_q         <= 8'd0;
            runs_done_q   <= 8'd0;
            load_done_q   <= 1'b0;
            run_done_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            stop_q        <= 1'b0;
            flag_seen_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            byte_cnt_q    <= byte_cnt_d;
            dato_q        <= dato_d;
            mode_q        <= mode_d;
            mux_q         <= mux_d;
            count_q       <= count_d;
            remain_q      <= remain_d;
            gap_q         <= gap_d;
            runs_done_q   <= runs_done_d;
            load_done_q   <= load_done_d;
            run_done_q    <= run_done_d;
            err_timeout_q <= err_timeout_d;
            stop_q        <= stop_d;
            flag_seen_q   <= flag_seen_d;
        end
    end

    // Decoded straight from state so that reset removes wr/stb without waiting for a clock.
    assign cmd.cmd_ready = ld_wait;
    assign seq_en        = (state_q == StArm);
    assign wr            = (state_q == StLdWait) || (state_q == StLdHi) ||
                           (state_q == StLdLo) || (state_q == StLdFlush);
    assign stb           = (state_q == StLdHi) ||
                           ((state_q == StLdFlush) && (tmr_q < TmrW'(STB_W)));
    assign busy          = (state_q != StIdle);
    assign dato          = dato_q;
    assign mode          = mode_q;
    assign mux_cont_en   = mux_q;
    assign load_done     = load_done_q;
    assign run_done      = run_done_q;
    assign err_timeout   = err_timeout_q;
    assign runs_done     = runs_done_q;

endmodule

// File: tb/tb_seq_scheduler.sv
// Directed bench for seq_scheduler with default parameters (64 words, 64-cycle runs, STB_W=2).
module tb_seq_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_req = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] run_mode = 2'b00;
    logic [7:0] run_count = 8'd0;
    logic [7:0] gap_cycles = 8'd0;
    logic [7:0] mux_limit = 8'd0;
    logic       flag_adc = 1'b0;
    logic       seq_en, wr, stb;
    logic [7:0] dato;
    logic [1:0] mode;
    logic [7:0] mux_cont_en;
    logic       busy, load_done, run_done, err_timeout;
    logic [7:0] runs_done;

    seq_scheduler_if cmd_if ();

    always #5 clk = ~clk;

    seq_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd_if),
        .load_req    (load_req),
        .start       (start),
        .stop        (stop),
        .run_mode    (run_mode),
        .run_count   (run_count),
        .gap_cycles  (gap_cycles),
        .mux_limit   (mux_limit),
        .flag_adc    (flag_adc),
        .seq_en      (seq_en),
        .wr          (wr),
        .stb         (stb),
        .dato        (dato),
        .mode        (mode),
        .mux_cont_en (mux_cont_en),
        .busy        (busy),
        .load_done   (load_done),
        .run_done    (run_done),
        .err_timeout (err_timeout),
        .runs_done   (runs_done)
    );

    int n_chk = 0;
    int n_bad = 0;
    int hs_to = 0;

    // Monitor: samples on the falling edge, only ever counts up.
    int         cyc = 0;
    int         stb_rises = 0;
    int         stb_hi_cyc = 0;
    int         wr_bad = 0;
    int         dato_bad = 0;
    logic [7:0] stb_dato [256];
    logic [7:0] rise_dato = 8'd0;
    int         seq_cnt = 0;
    int         seq_long = 0;
    int         seq_t [16];
    int         rd_cnt = 0;
    int         rd_cyc = 0;
    int         to_cnt = 0;
    int         to_alone = 0;
    int         busy_fall = 0;
    logic       stb_prev = 1'b0, wr_prev = 1'b0, seq_prev = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (stb) stb_hi_cyc <= stb_hi_cyc + 1;
        if (stb && !stb_prev) begin
            stb_dato[stb_rises % 256] <= dato;
            rise_dato <= dato;
            stb_rises <= stb_rises + 1;
            if (!wr || !wr_prev) wr_bad <= wr_bad + 1;
        end
        if (stb && stb_prev && (dato != rise_dato)) dato_bad <= dato_bad + 1;
        if (seq_en) begin
            if (seq_prev) seq_long <= seq_long + 1;
            else begin
                seq_t[seq_cnt % 16] <= cyc;
                seq_cnt <= seq_cnt + 1;
            end
        end
        if (run_done) begin
            rd_cnt <= rd_cnt + 1;
            rd_cyc <= cyc;
            if (err_timeout) to_cnt <= to_cnt + 1;
        end
        if (err_timeout && !run_done) to_alone <= to_alone + 1;
        if (busy_prev && !busy) busy_fall <= cyc;
        stb_prev  <= stb;
        wr_prev   <= wr;
        seq_prev  <= seq_en;
        busy_prev <= busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic done;
        done = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = b;
        for (int k = 0; k < 200 && !done; k++) begin
            if (cmd_if.cmd_ready) done = 1'b1;
            tick(1);
        end
        cmd_if.cmd_valid = 1'b0;
        if (!done) hs_to++;
    endtask

    // Sends bytes 0..nbytes-1 with random idle gaps; a start pulse is slipped in mid-load.
    task automatic do_load(input int nbytes);
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            tick($urandom_range(0, 2));
            if (i == 10) begin
                start = 1'b1;
                tick(1);
                start = 1'b0;
            end
            send_byte(i[7:0]);
        end
    endtask

    task automatic wait_idle(input string tag, input int bound);
        for (int k = 0; k < bound && busy; k++) tick(1);
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_seq(input string tag, input int bound);
        for (int k = 0; k < bound && !seq_en; k++) tick(1);
        check(tag, {31'd0, seq_en}, 32'd1);
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [7:0] cnt, input logic [7:0] gap,
                               input logic [7:0] mux);
        run_mode   = m;
        run_count  = cnt;
        gap_cycles = gap;
        mux_limit  = mux;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic pulse_flag();
        tick(10);
        flag_adc = 1'b1;
        tick(1);
        flag_adc = 1'b0;
    endtask

    int b_stb, b_hi, b_wr, b_dbad, b_seq, b_rd, b_to;

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = 8'd0;

        // Outputs while held in reset.
        #23;
        check("rst_outs", {seq_en, wr, stb, dato, mode, mux_cont_en, cmd_if.cmd_ready, busy,
                           load_done, run_done, err_timeout, runs_done}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Table select 3 without a table is refused.
        b_seq = seq_cnt;
        pulse_start(2'b11, 8'd1, 8'd0, 8'd5);
        tick(3);
        check("m3_noload_busy", {31'd0, busy}, 32'd0);
        check("m3_noload_seq", seq_cnt - b_seq, 0);

        // Reset in the middle of a download.
        hs_to = 0;
        do_load(40);
        check("ab_stb_hi", {30'd0, wr, stb}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("ab_async", {29'd0, wr, stb, load_done}, 32'd0);
        #10 rst_n = 1'b1;
        tick(1);
        check("ab_after", {30'd0, busy, load_done}, 32'd0);

        // Full download: 128 bytes plus a zero flush strobe.
        b_stb = stb_rises; b_hi = stb_hi_cyc; b_wr = wr_bad; b_dbad = dato_bad; b_seq = seq_cnt;
        do_load(128);
        wait_idle("ld_idle", 100);
        tick(2);
        check("ld_hs", hs_to, 0);
        check("ld_pulses", stb_rises - b_stb, 129);
        check("ld_width", stb_hi_cyc - b_hi, 258);
        check("ld_wr_env", wr_bad - b_wr, 0);
        check("ld_dato_hold", dato_bad - b_dbad, 0);
        check("ld_first", {24'd0, stb_dato[b_stb % 256]}, 32'h00);
        check("ld_second", {24'd0, stb_dato[(b_stb + 1) % 256]}, 32'h01);
        check("ld_last_byte", {24'd0, stb_dato[(b_stb + 127) % 256]}, 32'h7f);
        check("ld_flush", {24'd0, stb_dato[(b_stb + 128) % 256]}, 32'h00);
        check("ld_done", {29'd0, load_done, wr, stb}, 32'd4);
        check("ld_no_start", seq_cnt - b_seq, 0);

        // Table select 3 after a load is accepted; flag_adc low gives err_timeout.
        b_seq = seq_cnt; b_rd = rd_cnt; b_to = to_cnt;
        pulse_start(2'b11, 8'd0, 8'd0, 8'd9);
        wait_seq("m3_seq", 5);
        check("m3_mode", {22'd0, mode, mux_cont_en}, {22'd0, 2'b11, 8'd9});
        tick(5);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_idle("m3_idle", 200);
        tick(2);
        check("m3_runs", seq_cnt - b_seq, 1);
        check("to_rd", rd_cnt - b_rd, 1);
        check("to_with_rd", to_cnt - b_to, 1);
        check("to_alone", to_alone, 0);
        check("m3_runs_done", {24'd0, runs_done}, 32'd1);

        // Three counted runs with a 5-cycle gap.
        b_seq = seq_cnt; b_rd = rd_cnt; b_to = to_cnt;
        pulse_start(2'b01, 8'd3, 8'd5, 8'h2a);
        wait_seq("cnt_seq1", 5);
        check("cnt_cleared", {24'd0, runs_done}, 32'd0);
        check("cnt_mode", {22'd0, mode, mux_cont_en}, {22'd0, 2'b01, 8'h2a});
        pulse_flag();
        wait_seq("cnt_seq2", 100);
        pulse_flag();
        wait_seq("cnt_seq3", 100);
        check("cnt_mode_hold", {30'd0, mode}, 32'd1);
        pulse_flag();
        wait_idle("cnt_idle", 200);
        tick(2);
        check("cnt_runs", seq_cnt - b_seq, 3);
        check("cnt_space12", seq_t[(b_seq + 1) % 16] - seq_t[b_seq % 16], 69);
        check("cnt_space23", seq_t[(b_seq + 2) % 16] - seq_t[(b_seq + 1) % 16], 69);
        check("cnt_rd_lat", rd_cyc - seq_t[(b_seq + 2) % 16], 63);
        check("cnt_runs_done", {24'd0, runs_done}, 32'd3);
        check("cnt_no_to", to_cnt - b_to, 0);
        check("seq_one_cycle", seq_long, 0);

        // Continuous runs, stop during run 2.
        b_seq = seq_cnt;
        pulse_start(2'b10, 8'd0, 8'd2, 8'd3);
        wait_seq("cont_seq1", 5);
        pulse_flag();
        wait_seq("cont_seq2", 100);
        tick(20);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        flag_adc = 1'b1;
        tick(1);
        flag_adc = 1'b0;
        wait_idle("cont_idle", 200);
        tick(100);
        check("cont_runs", seq_cnt - b_seq, 2);
        check("cont_runs_done", {24'd0, runs_done}, 32'd2);
        check("cont_busy_fall", busy_fall - seq_t[(b_seq + 1) % 16], 66);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_scheduler.md
SEQ_SCHEDULER -- requirements
Module: seq_scheduler

Interface
REQ-001 Parameter WORDS, default 64, meaning: number of 16-bit words in the downloadable sequence table.
REQ-002 Parameter SEQ_LEN, default 64, meaning: clock cycles per sequencer run; seq_en pulse to counter saturation.
REQ-003 Parameter STB_W, default 2, meaning: clk cycles stb is held high, and then held low, per strobe.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  host byte handshake; a byte transfers when both are high on a clk edge.
REQ-008 cmd_data  in  8  table byte, high byte first within each word.
REQ-009 load_req  in  1  single-cycle pulse that starts a table download.
REQ-010 start / stop  in / in  1 / 1  single-cycle run start and graceful stop requests.
REQ-011 run_mode, run_count, gap_cycles, mux_limit  in  2, 8, 8, 8  values latched at start; run_count=0 means continuous.
REQ-012 flag_adc  in  1  ADC-window flag returned by the sequencer.
REQ-013 seq_en, wr, stb  out  1 each  sequencer restart, write-enable, and write-strobe.
REQ-014 dato, mode, mux_cont_en  out  8, 2, 8  sequencer byte, table select, and mux enable limit.
REQ-015 busy, load_done, run_done, err_timeout  out  1 each  status; run_done and err_timeout are one-cycle pulses.
REQ-016 runs_done  out  8  completed-run counter; wraps from 255 to 0.

Function
REQ-017 The FSM SHALL have these states: IDLE, LD_WAIT, LD_HI, LD_LO, LD_FLUSH, ARM, RUN, GAP.
REQ-018 IDLE: load_req SHALL enter LD_WAIT, clear load_done, and raise wr; start SHALL enter ARM; load_req SHALL win if both are asserted together.
REQ-019 LD_WAIT SHALL assert cmd_ready; on transfer it SHALL register the byte onto dato and go to LD_HI; cmd_ready SHALL be 0 in every other state.
REQ-020 LD_HI SHALL drive stb=1 for STB_W cycles, then LD_LO SHALL drive stb=0 for STB_W cycles; dato SHALL stay stable throughout.
REQ-021 After 2*WORDS bytes, the FSM SHALL enter LD_FLUSH, issue one extra strobe with dato=0 so the last word commits, then drop wr, set load_done, and return to IDLE.
REQ-022 wr SHALL be high only in LD_* states and SHALL rise at least one cycle before the first stb rising edge.
REQ-023 start in any LD_* state SHALL be ignored.
REQ-024 start with run_mode=2'b11 and load_done=0 SHALL be ignored.
REQ-025 ARM SHALL latch the run parameters, drive mode and mux_cont_en from them, pulse seq_en for exactly one cycle, and enter RUN on the next cycle.
REQ-026 RUN SHALL count SEQ_LEN-1 cycles from the seq_en pulse, then enter GAP with a one-cycle run_done pulse and increment runs_done.
REQ-027 If flag_adc was not seen high during RUN, run_done SHALL coincide with a one-cycle err_timeout pulse.
REQ-028 GAP SHALL wait gap_cycles cycles (0 gives 0 extra cycles) and then go to ARM if runs remain, else to IDLE.
REQ-029 The remaining-run count SHALL decrement at each run_done; the decrement SHALL be skipped when the latched run_count is 0.
REQ-030 stop SHALL be sticky until IDLE and SHALL let the current RUN finish; a stop pending at the end of RUN SHALL make GAP go to IDLE.
REQ-031 mode and mux_cont_en SHALL hold their latched values from ARM until IDLE is re-entered.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 runs_done SHALL clear at each accepted start.

Reset
REQ-034 When rst_n is low, the FSM SHALL go to IDLE and these outputs SHALL be 0: seq_en, wr, stb, dato, mode, mux_cont_en, cmd_ready, busy, load_done, run_done, err_timeout, runs_done.
REQ-035 Reset during a download SHALL abort it with wr=0 and stb=0 immediately; load_done SHALL stay 0 until a full reload completes.

Verification
REQ-036 Bench scenario: load_req, then 128 bytes 0x00..0x7F with random valid gaps -> 129 stb pulses, last with dato=0; wr envelopes all of them; load_done=1.
REQ-037 Bench scenario: start, run_mode=01, run_count=3, gap_cycles=5, flag_adc pulsed each run -> 3 seq_en pulses spaced 64+5 cycles apart; runs_done=3; then IDLE.
REQ-038 Bench scenario: start, run_count=0, stop asserted mid-run 2 -> run 2 completes; no further seq_en; busy falls after GAP.
REQ-039 Bench scenario: start with run_mode=11 and no load -> ignored, busy=0; repeat after a load -> accepted.
REQ-040 Bench scenario: flag_adc held low during a run -> err_timeout pulses together with run_done.
REQ-041 Bench scenario: rst_n low after byte 40 of a download -> wr=0 and stb=0 asynchronously; load_done=0; a full reload then succeeds.
